// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - command handshake bundle between fetch stage and pc_sequencer
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [2:0]       CMD;
  logic [WIDTH-1:0] TARGET;

  modport master (
    output CMD_VALID,
    output CMD,
    output TARGET,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD,
    input  TARGET,
    output CMD_READY
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer over a chain of 74161 nibble counters
// Optional HALT/RESUME support is built when PC_SEQ_HALT_EN is defined.

module chip74161 (
  input  logic       CLK,
  input  logic       N_CLR,
  input  logic       N_LOAD,
  input  logic       ENP,
  input  logic       ENT,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       RCO
);
  always_ff @(posedge CLK or negedge N_CLR) begin
    if (!N_CLR)
      Q <= 4'd0;
    else if (!N_LOAD)
      Q <= D;
    else if (ENP && ENT)
      Q <= Q + 4'd1;
  end

  assign RCO = ENT & (&Q);
endmodule

module pc_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   N_CLR,
  pc_sequencer_if.slave          cmd_if,
  input  logic                   RESUME,
  output logic [WIDTH-1:0]       PC,
  output logic [$clog2(DEPTH):0] SP,
  output logic                   ERR,
  output logic                   HALTED
);
  localparam int NIB = WIDTH / 4;
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_JMP  = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;
  localparam logic [2:0] CMD_SKIP = 3'd5;
`ifdef PC_SEQ_HALT_EN
  localparam logic [2:0] CMD_HALT = 3'd6;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP2 = 2'd1
`ifdef PC_SEQ_HALT_EN
    , ST_HALTED = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack [DEPTH];

  logic             accept;
  logic             do_load;
  logic             do_count;
  logic             push;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pc_inc;
  logic [SPW-1:0]   sp_m1;
  logic [AW-1:0]    top_idx;
  logic             n_load;
  logic             enp;
  logic [NIB-1:0]   rco;
  logic [NIB-1:0]   ent;
  logic             unused_rco;

  // Ready is forced low while reset is held so nothing is accepted during clear.
  assign cmd_if.CMD_READY = N_CLR && (state_q == ST_IDLE);
  assign accept           = cmd_if.CMD_VALID && cmd_if.CMD_READY;
  assign pc_inc           = PC + WIDTH'(1);
  assign sp_m1            = sp_q - SPW'(1);
  assign top_idx          = sp_m1[AW-1:0];

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    err_d    = err_q;
    do_load  = 1'b0;
    do_count = 1'b0;
    push     = 1'b0;
    load_val = cmd_if.TARGET;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_if.CMD)
            CMD_INC: do_count = 1'b1;
            CMD_JMP: do_load = 1'b1;
            CMD_CALL: begin
              if (sp_q == SPW'(DEPTH)) begin
                err_d = 1'b1;
              end else begin
                do_load = 1'b1;
                push    = 1'b1;
                sp_d    = sp_q + SPW'(1);
              end
            end
            CMD_RET: begin
              if (sp_q == '0) begin
                err_d = 1'b1;
              end else begin
                do_load  = 1'b1;
                load_val = stack[top_idx];
                sp_d     = sp_m1;
              end
            end
            CMD_SKIP: begin
              do_count = 1'b1;
              state_d  = ST_SKIP2;
            end
`ifdef PC_SEQ_HALT_EN
            CMD_HALT: state_d = ST_HALTED;
`endif
            default: ;
          endcase
        end
      end
      ST_SKIP2: begin
        do_count = 1'b1;
        state_d  = ST_IDLE;
      end
`ifdef PC_SEQ_HALT_EN
      ST_HALTED: begin
        if (RESUME)
          state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge N_CLR) begin
    if (!N_CLR) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return stack is not cleared by reset; SP alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (push)
      stack[sp_q[AW-1:0]] <= pc_inc;
  end

  assign n_load = !do_load;
  assign enp    = do_count && !do_load;
  assign ent    = {rco[NIB-2:0], enp};

  for (genvar n = 0; n < NIB; n++) begin : g_nib
    chip74161 u_nib (
      .CLK    (CLK),
      .N_CLR  (N_CLR),
      .N_LOAD (n_load),
      .ENP    (enp),
      .ENT    (ent[n]),
      .D      (load_val[4*n +: 4]),
      .Q      (PC[4*n +: 4]),
      .RCO    (rco[n])
    );
  end

  assign unused_rco = rco[NIB-1];
  assign SP         = sp_q;
  assign ERR        = err_q;

`ifdef PC_SEQ_HALT_EN
  assign HALTED = (state_q == ST_HALTED);
`else
  logic unused_resume;
  assign unused_resume = RESUME;
  assign HALTED        = 1'b0;
`endif
endmodule
